// File: rtl/float_to_fixed.sv
// IEEE-754 single-precision to signed fixed-point converter (FRAC_BITS fraction bits), handshaked.
// Define FLOAT_TO_FIXED_ROUND_EN for round-to-nearest-even; otherwise the magnitude truncates toward zero.
module float_to_fixed #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_ovf,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    UNPACK = 3'd1,
    ALIGN  = 3'd2,
    ROUND  = 3'd3,
    PACK   = 3'd4,
    PUT_Z  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic        stb_q, stb_d;
  logic [31:0] z_q, z_d;
  logic        ovf_q, ovf_d;

  logic [31:0] a_q;
  logic        s_q, zero_q, inf_q, nan_q, lovf_q;
  logic [7:0]  e_q;
  logic [23:0] m_q;
  logic [32:0] mag_q;
  logic [33:0] rmag_q;

  logic signed [9:0] k_s;
  logic [9:0]        nsh_s;
  logic [32:0]       align_mag_s;
  logic              align_ovf_s;
  logic              inc_s;
  logic [33:0]       rmag_s;

`ifdef FLOAT_TO_FIXED_ROUND_EN
  logic        guard_q, round_q, sticky_q;
  logic        align_g_s, align_r_s, align_st_s;
  logic [49:0] wide_s;
`endif

  // State register and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      z_q     <= 32'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: fixed walk through the pipeline stages
  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_A:  if (ack_q && input_a_stb) state_d = UNPACK; else state_d = GET_A;
      UNPACK: state_d = ALIGN;
      ALIGN:  state_d = ROUND;
      ROUND:  state_d = PACK;
      PACK:   state_d = PUT_Z;
      PUT_Z:  if (stb_q && output_z_ack) state_d = GET_A; else state_d = PUT_Z;
      default: state_d = GET_A;
    endcase
  end

  // Shift amount relative to the mantissa's implied binary point
  always_comb begin
    k_s   = $signed({2'b00, e_q}) - 10'sd150 + 10'(FRAC_BITS);
    nsh_s = 10'(-k_s);
  end

  // Align mantissa into a 33-bit magnitude, tracking guard/round/sticky on right shifts
  always_comb begin
    align_mag_s = 33'd0;
    align_ovf_s = 1'b0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    align_g_s  = 1'b0;
    align_r_s  = 1'b0;
    align_st_s = 1'b0;
    wide_s     = 50'd0;
`endif
    if (!k_s[9]) begin
      if (k_s > 10'sd9) begin
        align_ovf_s = 1'b1;
      end else begin
        align_mag_s = {9'd0, m_q} << k_s[3:0];
      end
    end else if (nsh_s >= 10'd26) begin
      align_mag_s = 33'd0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
      align_st_s = |m_q;
`endif
    end else begin
      align_mag_s = {9'd0, m_q >> nsh_s[4:0]};
`ifdef FLOAT_TO_FIXED_ROUND_EN
      wide_s     = {m_q, 26'd0} >> nsh_s[4:0];
      align_g_s  = wide_s[25];
      align_r_s  = wide_s[24];
      align_st_s = |wide_s[23:0];
`endif
    end
  end

  // Rounding increment; the 34-bit sum keeps any carry for the saturation check
  always_comb begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
    inc_s = guard_q && (round_q || sticky_q || mag_q[0]);
`else
    inc_s = 1'b0;
`endif
    rmag_s = {1'b0, mag_q} + {33'd0, inc_s};
  end

  // Output logic: handshake flags and the packed result loaded on entry to PUT_Z
  always_comb begin
    ack_d = (state_d == GET_A);
    stb_d = (state_q == PUT_Z) && !(stb_q && output_z_ack);
    z_d   = z_q;
    ovf_d = ovf_q;
    if (state_q == PACK) begin
      if (nan_q) begin
        z_d   = 32'h0000_0000;
        ovf_d = 1'b1;
      end else if (inf_q || lovf_q || (!s_q && (rmag_q > 34'h0_7FFF_FFFF))
                   || (s_q && (rmag_q > 34'h0_8000_0000))) begin
        z_d   = s_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
        ovf_d = 1'b1;
      end else if (zero_q) begin
        z_d   = 32'h0000_0000;
        ovf_d = 1'b0;
      end else begin
        z_d   = s_q ? (~rmag_q[31:0] + 32'd1) : rmag_q[31:0];
        ovf_d = 1'b0;
      end
    end else begin
      z_d   = z_q;
      ovf_d = ovf_q;
    end
  end

  // Datapath registers, no reset needed: each stage only consumes values its predecessor wrote
  always_ff @(posedge clk) begin
    case (state_q)
      GET_A: begin
        if (ack_q && input_a_stb) a_q <= input_a;
      end
      UNPACK: begin
        s_q    <= a_q[31];
        e_q    <= a_q[30:23];
        m_q    <= {1'b1, a_q[22:0]};
        zero_q <= (a_q[30:23] == 8'd0);
        inf_q  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        nan_q  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
      end
      ALIGN: begin
        mag_q  <= align_mag_s;
        lovf_q <= align_ovf_s;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        guard_q  <= align_g_s;
        round_q  <= align_r_s;
        sticky_q <= align_st_s;
`endif
      end
      ROUND: begin
        rmag_q <= rmag_s;
      end
      default: ;
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = z_q;
  assign output_ovf   = ovf_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed self-checking bench for float_to_fixed with FRAC_BITS=16.
module tb_float_to_fixed;

  logic        clk;
  logic        rst_n;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_ovf;
  logic        output_z_stb;
  logic        output_z_ack;

  int tests_run;
  int tests_failed;

  float_to_fixed #(.FRAC_BITS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_ovf   (output_ovf),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input logic [31:0] a, input logic [31:0] ez, input logic eovf,
                         input int hold, input string tag);
    int  lat;
    bit  got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_a_ack) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, "_ack_wait"}, {31'd0, got}, 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    input_a     = 32'hDEAD_BEEF;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (output_z_stb) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_z"}, output_z, ez);
    check({tag, "_ovf"}, {31'd0, output_ovf}, {31'd0, eovf});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_z"}, output_z, ez);
      check({tag, "_hold_stb_ack"}, {30'd0, output_z_stb, input_a_ack}, 32'd2);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    output_z_ack = 1'b0;
    check({tag, "_handoff"}, {30'd0, output_z_stb, input_a_ack}, 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    #12;
    check("reset_outputs", {output_z[29:0], output_ovf, output_z_stb}, 32'd0);
    check("reset_ack", {31'd0, input_a_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ack_after_reset", {31'd0, input_a_ack}, 32'd1);

    run_vec(32'h3F80_0000, 32'h0001_0000, 1'b0, 0, "one");
    run_vec(32'hC020_0000, 32'hFFFD_8000, 1'b0, 10, "neg2p5_hold");
    run_vec(32'h4780_0000, 32'h7FFF_FFFF, 1'b1, 0, "pos_ovf");
    run_vec(32'hC700_0000, 32'h8000_0000, 1'b0, 0, "neg_min");
    run_vec(32'hFF80_0000, 32'h8000_0000, 1'b1, 0, "neg_inf");
    run_vec(32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 0, "pos_inf");
    run_vec(32'h7FC0_0000, 32'h0000_0000, 1'b1, 0, "nan");
    run_vec(32'h8000_0000, 32'h0000_0000, 1'b0, 0, "neg_zero");
    run_vec(32'h0040_0000, 32'h0000_0000, 1'b0, 0, "denormal");
    run_vec(32'h3700_0000, 32'h0000_0000, 1'b0, 0, "tie_even");
    run_vec(32'h0080_0000, 32'h0000_0000, 1'b0, 0, "tiny_normal");
`ifdef FLOAT_TO_FIXED_ROUND_EN
    run_vec(32'h3740_0000, 32'h0000_0001, 1'b0, 0, "round_up");
    run_vec(32'h37C0_0000, 32'h0000_0002, 1'b0, 0, "round_odd");
`else
    run_vec(32'h3740_0000, 32'h0000_0000, 1'b0, 0, "trunc_up");
    run_vec(32'h37C0_0000, 32'h0000_0001, 1'b0, 0, "trunc_odd");
`endif

    // Reset while the operand sits in ALIGN: nothing may emerge for it
    @(negedge clk);
    input_a     = 32'h40A0_0000;
    input_a_stb = 1'b1;
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {output_z[29:0], output_ovf, output_z_stb}, 32'd0);
    check("midreset_z_top", {30'd0, output_z[31:30]}, 32'd0);
    check("midreset_ack", {31'd0, input_a_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk);
        #1;
        if (output_z_stb) seen = 1'b1;
      end
      check("midreset_no_result", {31'd0, seen}, 32'd0);
    end
    run_vec(32'h3F80_0000, 32'h0001_0000, 1'b0, 0, "after_reset_one");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
